uart_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares the single TX path of `uart_fifo` among up to `NUM_REQ` on-chip requesters. Each requester streams bytes with valid/ready/last. The arbiter grants one requester at a time and forwards its bytes as `tx_byte`/`transmit` pushes, throttled by `tx_fifo_full`. It holds the grant until the packet's last byte, so bytes from different packets never interleave on the serial line. A stall watchdog reclaims the grant from a requester that stops mid-packet.

---
 rtl/uart_arb_pkg.sv | 22 ++
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART TX arbiter and its picker.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for n requesters. A single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Stall counter width. It only has to reach TIMEOUT-1.
    function automatic int stall_w(input int timeout);
        return (timeout <= 1) ? 1 : $clog2(timeout);
    endfunction

    // Index width of the default four-requester build.
    localparam int IDX_W = idx_w(4);

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from ptr_i+1, wrapping modulo NUM_REQ, and returns the first set request.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [W-1:0]       ptr_i,
    output logic               found_o,
    output logic [W-1:0]       index_o
);

    int         cand;
    logic [W-1:0] cand_idx;

    // The lowest offset from ptr_i+1 wins, so the last owner becomes lowest priority.
    always_comb begin
        found_o  = 1'b0;
        index_o  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr_i) + k) % NUM_REQ;
            cand_idx = W'(cand);
            if (!found_o && req_i[cand_idx]) begin
                found_o = 1'b1;
                index_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter that shares the uart_fifo TX path among NUM_REQ requesters.
// A grant is held until the owner's last byte is pushed.
// A stall watchdog takes the grant back from an owner that goes quiet mid-packet.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | no owner; arbitrate among valid requesters, grant on next cycle
//   GRANT | owner_q streams bytes into the fifo; stall counter watches valid
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      Pclk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [8*NUM_REQ-1:0]      req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_fifo_full,
    output logic [7:0]                tx_byte,
    output logic                      transmit,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_irq,
    output logic [idx_w(NUM_REQ)-1:0] timeout_id
);

    localparam int OWN_W = idx_w(NUM_REQ);
    localparam int CNT_W = stall_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             irq_q,   irq_d;
    logic [OWN_W-1:0] tid_q,   tid_d;

    logic [7:0]       lane [NUM_REQ];
    logic             pick_found;
    logic [OWN_W-1:0] pick_idx;
    logic             own_valid;
    logic             own_last;
    logic             handshake;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane[g] = req_data[8*g +: 8];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .W       (OWN_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    // Byte path: everything is combinational from the owner register, so there is no added latency.
    always_comb begin
        busy        = (state_q == GRANT);
        own_valid   = req_valid[owner_q];
        own_last    = req_last[owner_q];
        handshake   = busy && own_valid && !tx_fifo_full;
        grant       = busy ? (NUM_REQ'(1) << owner_q) : '0;
        req_ready   = tx_fifo_full ? '0 : grant;
        transmit    = handshake;
        tx_byte     = busy ? lane[owner_q] : 8'h00;
        timeout_irq = irq_q;
        timeout_id  = tid_q;
    end

    // Next-state logic: arbitration, packet end, and the stall watchdog.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;
        tid_d   = tid_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (handshake) begin
                    cnt_d = '0;
                    if (own_last) begin
                        ptr_d   = owner_q;
                        state_d = IDLE;
                    end
                end else if (!own_valid) begin
                    // Only a silent owner ages. A full fifo holds the count so backpressure never times out.
                    if (cnt_q == CNT_LAST) begin
                        irq_d   = 1'b1;
                        tid_d   = owner_q;
                        ptr_d   = owner_q;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset. ptr starts at the top so requester 0 wins first.
    always_ff @(posedge Pclk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= OWN_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            tid_q   <= tid_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 16-cycle stall timeout).
module tb_uart_tx_arbiter;

    logic        Pclk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_fifo_full;
    logic [7:0]  tx_byte;
    logic        transmit;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_irq;
    logic [1:0]  timeout_id;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (16)
    ) dut (
        .Pclk         (Pclk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_fifo_full (tx_fifo_full),
        .tx_byte      (tx_byte),
        .transmit     (transmit),
        .grant        (grant),
        .busy         (busy),
        .timeout_irq  (timeout_irq),
        .timeout_id   (timeout_id)
    );

    always #5 Pclk = ~Pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Advance to just after the next rising edge; inputs are driven here, outputs sampled 2 ns later.
    task automatic nxt();
        @(posedge Pclk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic clr();
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        tx_fifo_full = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"},   32'(grant),       32'h0);
        chk({tag, "_busy"},    32'(busy),        32'h0);
        chk({tag, "_tx"},      32'(transmit),    32'h0);
        chk({tag, "_ready"},   32'(req_ready),   32'h0);
        chk({tag, "_byte"},    32'(tx_byte),     32'h0);
        chk({tag, "_irq"},     32'(timeout_irq), 32'h0);
        chk({tag, "_tid"},     32'(timeout_id),  32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int b [4];
        int pkt, bi, cyc_last, bad, sent;
        logic last_hs, prev_last_hs;
        logic [3:0] hs;

        rst = 1'b1;
        clr();
        nxt();

        // ---- reset values and a single 3-byte packet from requester 2
        nxt();
        #2;
        chk_reset_outputs("rst");
        nxt();
        rst = 1'b0;
        set_lane(2, 1'b1, 8'h41, 1'b0);
        #2;
        chk("p1_idle_grant", 32'(grant), 32'h0);
        nxt();
        #2;
        chk("p1_grant", 32'(grant), 32'h4);
        chk("p1_busy", 32'(busy), 32'h1);
        chk("p1_ready", 32'(req_ready), 32'h4);
        chk("p1_tx0", 32'(transmit), 32'h1);
        chk("p1_b0", 32'(tx_byte), 32'h41);
        nxt();
        set_lane(2, 1'b1, 8'h42, 1'b0);
        #2;
        chk("p1_tx1", 32'(transmit), 32'h1);
        chk("p1_b1", 32'(tx_byte), 32'h42);
        nxt();
        set_lane(2, 1'b1, 8'h43, 1'b1);
        #2;
        chk("p1_tx2", 32'(transmit), 32'h1);
        chk("p1_b2", 32'(tx_byte), 32'h43);
        nxt();
        set_lane(2, 1'b0, 8'h00, 1'b0);
        #2;
        chk("p1_busy_drop", 32'(busy), 32'h0);
        chk("p1_grant_drop", 32'(grant), 32'h0);

        // ---- round robin: all four stream 2-byte packets, byte = {id, index}
        do_reset();
        for (int i = 0; i < 4; i++) b[i] = 0;
        pkt = 0; bi = 0; cyc_last = -1; prev_last_hs = 1'b0;
        for (int c = 0; c < 40 && pkt < 8; c++) begin
            for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 8'((i << 4) | b[i]), b[i] == 1);
            #2;
            if (prev_last_hs) chk("rr_bubble", 32'(busy), 32'h0);
            last_hs = 1'b0;
            if (busy) chk("rr_grant", 32'(grant), 32'(1 << (pkt % 4)));
            if (transmit) begin
                chk("rr_byte", 32'(tx_byte), 32'(((pkt % 4) << 4) | bi));
                if (bi == 1) begin
                    last_hs  = 1'b1;
                    cyc_last = c;
                    pkt++;
                    bi = 0;
                end else begin
                    bi = 1;
                end
            end
            prev_last_hs = last_hs;
            hs = req_valid & req_ready;
            nxt();
            for (int i = 0; i < 4; i++) if (hs[i]) b[i] = 1 - b[i];
        end
        chk("rr_pkts", 32'(pkt), 32'd8);
        chk("rr_last_cycle", 32'(cyc_last), 32'd23);

        // ---- backpressure for 2000 cycles mid-packet
        do_reset();
        set_lane(0, 1'b1, 8'hA0, 1'b0);
        nxt();
        #2;
        chk("bp_b0", 32'(tx_byte), 32'hA0);
        chk("bp_tx0", 32'(transmit), 32'h1);
        nxt();
        set_lane(0, 1'b1, 8'hA1, 1'b0);
        tx_fifo_full = 1'b1;
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            #2;
            if (transmit !== 1'b0 || req_ready !== 4'h0 || timeout_irq !== 1'b0 || busy !== 1'b1) bad++;
            nxt();
        end
        chk("bp_quiet", 32'(bad), 32'd0);
        tx_fifo_full = 1'b0;
        #2;
        chk("bp_resume_tx", 32'(transmit), 32'h1);
        chk("bp_resume_b1", 32'(tx_byte), 32'hA1);
        nxt();
        set_lane(0, 1'b1, 8'hA2, 1'b1);
        #2;
        chk("bp_b2", 32'(tx_byte), 32'hA2);
        nxt();
        set_lane(0, 1'b0, 8'h00, 1'b0);
        #2;
        chk("bp_done_busy", 32'(busy), 32'h0);
        chk("bp_done_irq", 32'(timeout_irq), 32'h0);

        // ---- back-to-back single-byte packets from requester 3
        do_reset();
        sent = 0; bad = 0;
        for (int k = 0; k < 9; k++) begin
            set_lane(3, sent < 4, 8'(8'hB0 + sent), 1'b1);
            #2;
            chk("sb_tx", 32'(transmit), 32'((k % 2 == 1) && (k <= 7)));
            if ((k % 2 == 1) && (k <= 7)) chk("sb_byte", 32'(tx_byte), 32'(8'hB0 + (k - 1) / 2));
            if (transmit) sent++;
            nxt();
        end
        chk("sb_count", 32'(sent), 32'd4);
        set_lane(3, 1'b0, 8'h00, 1'b0);

        // ---- stall timeout on requester 1, then requester 2 is next
        nxt();
        set_lane(1, 1'b1, 8'h55, 1'b0);
        #2;
        chk("to_idle", 32'(busy), 32'h0);
        nxt();
        #2;
        chk("to_grant", 32'(grant), 32'h2);
        chk("to_b0", 32'(tx_byte), 32'h55);
        nxt();
        set_lane(1, 1'b0, 8'h00, 1'b0);
        set_lane(2, 1'b1, 8'h66, 1'b1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            #2;
            if (busy !== 1'b1 || grant !== 4'h2 || timeout_irq !== 1'b0 || transmit !== 1'b0) bad++;
            nxt();
        end
        chk("to_hold", 32'(bad), 32'd0);
        #2;
        chk("to_irq", 32'(timeout_irq), 32'h1);
        chk("to_id", 32'(timeout_id), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        nxt();
        #2;
        chk("to_irq_pulse", 32'(timeout_irq), 32'h0);
        chk("to_next_grant", 32'(grant), 32'h4);
        chk("to_id_held", 32'(timeout_id), 32'h1);
        chk("to_next_byte", 32'(tx_byte), 32'h66);
        nxt();
        set_lane(2, 1'b0, 8'h00, 1'b0);

        // ---- reset mid-packet; requester 0 has priority afterwards
        nxt();
        set_lane(0, 1'b1, 8'hD0, 1'b1);
        nxt();
        #2;
        chk("mr_pre_grant", 32'(grant), 32'h1);
        nxt();
        set_lane(0, 1'b0, 8'h00, 1'b0);
        set_lane(2, 1'b1, 8'hC0, 1'b0);
        nxt();
        #2;
        chk("mr_grant2", 32'(grant), 32'h4);
        nxt();
        set_lane(2, 1'b1, 8'hC1, 1'b0);
        set_lane(0, 1'b1, 8'hD1, 1'b1);
        rst = 1'b1;
        #2;
        chk("mr_byte2", 32'(tx_byte), 32'hC1);
        nxt();
        rst = 1'b0;
        #2;
        chk_reset_outputs("mr");
        nxt();
        #2;
        chk("mr_prio0", 32'(grant), 32'h1);
        chk("mr_prio0_byte", 32'(tx_byte), 32'hD1);
        nxt();
        clr();
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
